// File: rtl/digits_conv.sv
// ---------------------------------------------------------------------------
// digits_conv
//
// Purpose
//   This block produces NDIG 4-bit digit codes for the seven-segment scanner.
//   It takes them from the 32-bit CPU-visible display register in one of two
//   ways:
//     * BCD pass-through (mode=0). The low 4*NDIG bits are registered
//       unchanged, with 1-cycle latency. Nibbles A-F pass through untouched.
//     * Binary-to-BCD (mode=1). digit_reg[DATA_W-1:0] is converted by a
//       sequential shift-add-3 (double-dabble) engine. The engine handles one
//       input bit per clock.
//   If the binary value does not fit in NDIG digits, the output saturates to
//   all 9s and overflow is raised.
//
// Optional feature (compile-time macro LZ_BLANK_EN)
//   Defined:   leading zeros above digit 0 are blanked. Blanked positions are
//              driven with BLANK_CODE and flagged in blank_mask. Overflow
//              saturation 9s are never blanked.
//   Undefined: blank_mask is constant 0 and digits carry the raw values.
//
// Parameters
//   NDIG       number of output digits (1..8)
//   DATA_W     binary-mode input width (1..32)
//   BLANK_CODE code driven on blanked positions (LZ_BLANK_EN only)
//
// Ports
//   clk_10Hz    in   display-domain clock
//   reset       in   asynchronous, active-low reset
//   digit_reg   in   [31:0] source value (packed BCD or binary)
//   mode        in   0 = BCD pass-through, 1 = binary conversion
//   hold        in   1 = freeze outputs / suppress new capture (sampled in IDLE)
//   digits      out  [4*NDIG-1:0] digit codes; digit i = digits[4i+3:4i], i=0 ones
//   blank_mask  out  [NDIG-1:0] 1 = digit position blanked
//   overflow    out  binary value exceeded 10^NDIG-1
//   busy        out  conversion in progress (SHIFT or COMMIT)
//   valid       out  1-cycle pulse on every output update
//   dbg_state   out  [1:0] current FSM state (0 IDLE, 1 SHIFT, 2 COMMIT)
//
// Output qualifier: there is no ready/backpressure. valid is high for exactly
// the one cycle following each edge on which digits/blank_mask/overflow were
// written. The consumer may sample those outputs whenever valid is high, or at
// any later time; they remain stable until the next valid pulse.
// ---------------------------------------------------------------------------
module digits_conv #(
    parameter int          NDIG       = 4,
    parameter int          DATA_W     = 16,
    parameter logic [3:0]  BLANK_CODE = 4'hF
) (
    input  logic                clk_10Hz,
    input  logic                reset,
    input  logic [31:0]         digit_reg,
    input  logic                mode,
    input  logic                hold,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     blank_mask,
    output logic                overflow,
    output logic                busy,
    output logic                valid,
    output logic [1:0]          dbg_state
);

    localparam int AW = 4 * NDIG;
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    // Double-dabble correction: any BCD nibble >= 5 would become >= 10 after
    // the shift, so pre-add 3 to make the carry land in the next nibble.
    function automatic logic [AW-1:0] add3_nibbles(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = a;
        for (int i = 0; i < NDIG; i++) begin
            if (a[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

`ifdef LZ_BLANK_EN
    // Position i (i>=1) is blanked when it and every higher digit are zero.
    // The ones digit always stays visible, so a zero value still shows "0".
    function automatic logic [NDIG-1:0] lz_mask(input logic [AW-1:0] d);
        logic [NDIG-1:0] m;
        logic            zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            zero_above = zero_above & (d[4*i +: 4] == 4'h0);
            m[i]       = zero_above;
        end
        return m;
    endfunction

    function automatic logic [AW-1:0] apply_blank(input logic [AW-1:0] d,
                                                  input logic [NDIG-1:0] m);
        logic [AW-1:0] r;
        r = d;
        for (int i = 0; i < NDIG; i++) begin
            if (m[i]) begin
                r[4*i +: 4] = BLANK_CODE;
            end
        end
        return r;
    endfunction
`endif

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t                 r_state;
    logic [DATA_W-1:0]      r_bin;
    logic [AW-1:0]          r_acc;
    logic                   r_sticky;
    logic [CW-1:0]          r_cnt;
    logic [AW-1:0]          r_digits;
    logic [NDIG-1:0]        r_blank;
    logic                   r_overflow;
    logic                   r_valid;

    // Next-state / update signals
    state_t                 w_state_nxt;
    logic [DATA_W-1:0]      w_bin_nxt;
    logic [AW-1:0]          w_acc_nxt;
    logic                   w_sticky_nxt;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   w_upd;
    logic [AW-1:0]          w_upd_val;
    logic                   w_upd_ovf;
    logic                   w_upd_sat;
    logic [AW-1:0]          w_adj;
    logic [AW-1:0]          w_disp;
    logic [NDIG-1:0]        w_mask;
    logic                   w_unused;

    // Which digit_reg bits matter depends on mode and parameters.
    assign w_unused = ^digit_reg;

    assign w_adj = add3_nibbles(r_acc);

    // -----------------------------------------------------------------------
    // Next-state and update logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_bin_nxt    = r_bin;
        w_acc_nxt    = r_acc;
        w_sticky_nxt = r_sticky;
        w_cnt_nxt    = r_cnt;
        w_upd        = 1'b0;
        w_upd_val    = '0;
        w_upd_ovf    = 1'b0;
        w_upd_sat    = 1'b0;

        case (r_state)
            IDLE: begin
                if (!hold) begin
                    if (!mode) begin
                        w_upd     = 1'b1;
                        w_upd_val = digit_reg[AW-1:0];
                    end else begin
                        w_bin_nxt    = digit_reg[DATA_W-1:0];
                        w_acc_nxt    = '0;
                        w_sticky_nxt = 1'b0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = SHIFT;
                    end
                end
            end

            SHIFT: begin
                // {acc, bin} <<= 1 after correction. The bit falling off the
                // top nibble would be a digit beyond NDIG, so it latches
                // overflow.
                w_acc_nxt    = {w_adj[AW-2:0], r_bin[DATA_W-1]};
                w_bin_nxt    = r_bin << 1;
                w_sticky_nxt = r_sticky | w_adj[AW-1];
                w_cnt_nxt    = r_cnt + CW'(1);
                if (r_cnt == CW'(DATA_W - 1)) begin
                    w_state_nxt = COMMIT;
                end
            end

            COMMIT: begin
                w_upd       = 1'b1;
                w_state_nxt = IDLE;
                if (r_sticky) begin
                    w_upd_val = {NDIG{4'h9}};
                    w_upd_ovf = 1'b1;
                    w_upd_sat = 1'b1;
                end else begin
                    w_upd_val = r_acc;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Blanking is computed on the value being written, so the mask and the
    // blanked codes land on the same edge as the digits.
`ifdef LZ_BLANK_EN
    assign w_mask = w_upd_sat ? '0 : lz_mask(w_upd_val);
    assign w_disp = apply_blank(w_upd_val, w_mask);
`else
    assign w_mask = '0;
    assign w_disp = w_upd_val;
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_10Hz or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_10Hz or negedge reset) begin
        if (!reset) begin
            r_bin      <= '0;
            r_acc      <= '0;
            r_sticky   <= 1'b0;
            r_cnt      <= '0;
            r_digits   <= '0;
            r_blank    <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_bin    <= w_bin_nxt;
            r_acc    <= w_acc_nxt;
            r_sticky <= w_sticky_nxt;
            r_cnt    <= w_cnt_nxt;
            r_valid  <= w_upd;
            if (w_upd) begin
                r_digits   <= w_disp;
                r_blank    <= w_mask;
                r_overflow <= w_upd_ovf;
            end
        end
    end

    assign digits     = r_digits;
    assign blank_mask = r_blank;
    assign overflow   = r_overflow;
    assign valid      = r_valid;
    // SHIFT and COMMIT together span exactly the capture-to-commit window.
    assign busy       = (r_state != IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_digits_conv.sv
module tb_digits_conv;

  localparam int NDIG   = 4;
  localparam int DATA_W = 16;

  logic              clk_10Hz = 1'b0;
  logic              reset    = 1'b0;
  logic [31:0]       digit_reg = 32'h0;
  logic              mode = 1'b0;
  logic              hold = 1'b0;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   blank_mask;
  logic              overflow;
  logic              busy;
  logic              valid;
  logic [1:0]        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

`ifdef LZ_BLANK_EN
  localparam logic [15:0] D7   = 16'hFFF7;
  localparam logic [3:0]  M7   = 4'b1110;
  localparam logic [15:0] D0   = 16'hFFF0;
  localparam logic [3:0]  M0   = 4'b1110;
  localparam logic [15:0] D100 = 16'hF100;
  localparam logic [3:0]  M100 = 4'b1000;
  localparam logic [15:0] DF0  = 16'hFFF0;
  localparam logic [3:0]  MF0  = 4'b1100;
`else
  localparam logic [15:0] D7   = 16'h0007;
  localparam logic [3:0]  M7   = 4'b0000;
  localparam logic [15:0] D0   = 16'h0000;
  localparam logic [3:0]  M0   = 4'b0000;
  localparam logic [15:0] D100 = 16'h0100;
  localparam logic [3:0]  M100 = 4'b0000;
  localparam logic [15:0] DF0  = 16'h00F0;
  localparam logic [3:0]  MF0  = 4'b0000;
`endif

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  always #5 clk_10Hz = ~clk_10Hz;

  digits_conv #(
    .NDIG      (NDIG),
    .DATA_W    (DATA_W),
    .BLANK_CODE(4'hF)
  ) dut (
    .clk_10Hz  (clk_10Hz),
    .reset     (reset),
    .digit_reg (digit_reg),
    .mode      (mode),
    .hold      (hold),
    .digits    (digits),
    .blank_mask(blank_mask),
    .overflow  (overflow),
    .busy      (busy),
    .valid     (valid),
    .dbg_state (dbg_state)
  );

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_10Hz);
    #1;
  endtask

  // Waits (bounded) for the next valid pulse; lat = edges waited, 0 on timeout.
  task automatic wait_valid(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_cnt++;
      tick();
      if (valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_conv(input string tag, input logic [31:0] val,
                          input logic [15:0] exp_d, input logic exp_ovf,
                          input logic [3:0] exp_m);
    int lat;
    int bc;
    int extra;
    logic [15:0] exp_digits;
    mode = 1'b1;
    hold = 1'b0;
    digit_reg = val;
    exp_q.push_back(exp_d);
    tick();  // capture edge
    check({tag, "_busy_after_capture"}, 32'(busy), 32'd1);
    check({tag, "_state_shift"}, 32'(dbg_state), 32'd1);
    // hold is ignored while converting; keeping it high stops a re-capture
    // after commit. digit_reg is scrambled to show it no longer matters.
    hold = 1'b1;
    digit_reg = $urandom;
    wait_valid(lat, bc);
    check({tag, "_latency"}, 32'(lat), 32'(DATA_W + 1));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(DATA_W + 1));
    exp_digits = exp_q.pop_front();
    check({tag, "_digits"}, 32'(digits), 32'(exp_digits));
    check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "_blank_mask"}, 32'(blank_mask), 32'(exp_m));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    extra = 0;
    repeat (3) begin
      tick();
      if (valid) extra++;
    end
    check({tag, "_single_valid"}, 32'(extra), 32'd0);
    check({tag, "_digits_held"}, 32'(digits), 32'(exp_digits));
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int lat;
    int bc;
    int vc;

    // Reset state with hostile inputs present
    reset = 1'b0;
    digit_reg = 32'hFFFF_FFFF;
    mode = 1'b1;
    hold = 1'b0;
    repeat (3) tick();
    check("rst_digits", 32'(digits), 32'h0000);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_blank_mask", 32'(blank_mask), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // Release: first edge captures 0xFFFF = 65535, which overflows 4 digits
    reset = 1'b1;
    tick();
    check("first_capture_busy", 32'(busy), 32'd1);
    hold = 1'b1;
    wait_valid(lat, bc);
    check("first_conv_latency", 32'(lat), 32'(DATA_W + 1));
    check("first_conv_digits", 32'(digits), 32'h9999);
    check("first_conv_overflow", 32'(overflow), 32'd1);

    // BCD pass-through
    mode = 1'b0;
    hold = 1'b0;
    digit_reg = 32'h0000_1234;
    tick();
    check("pt_digits", 32'(digits), 32'h1234);
    check("pt_valid", 32'(valid), 32'd1);
    check("pt_overflow_cleared", 32'(overflow), 32'd0);
    check("pt_blank_mask", 32'(blank_mask), 32'd0);
    tick();
    check("pt_valid_again", 32'(valid), 32'd1);
    hold = 1'b1;
    digit_reg = 32'h0000_5678;
    tick();
    check("pt_hold_digits", 32'(digits), 32'h1234);
    check("pt_hold_valid", 32'(valid), 32'd0);
    tick();
    check("pt_hold_digits2", 32'(digits), 32'h1234);
    hold = 1'b0;
    digit_reg = 32'hABCD_00F0;
    tick();
    check("pt_hex_digits", 32'(digits), 32'(DF0));
    check("pt_hex_mask", 32'(blank_mask), 32'(MF0));

    // Binary conversions
    run_conv("c4321", 32'd4321, 16'h4321, 1'b0, 4'b0000);
    run_conv("c12345", 32'd12345, 16'h9999, 1'b1, 4'b0000);
    run_conv("c9999", 32'd9999, 16'h9999, 1'b0, 4'b0000);
    run_conv("c10000", 32'd10000, 16'h9999, 1'b1, 4'b0000);
    run_conv("c7", 32'd7, D7, 1'b0, M7);
    run_conv("c0", 32'd0, D0, 1'b0, M0);
    run_conv("c100", 32'd100, D100, 1'b0, M100);
    run_conv("c1280", 32'd1280, 16'h1280, 1'b0, 4'b0000);

    // Mode switch 1->0 during SHIFT: commit first, then pass-through
    mode = 1'b1;
    hold = 1'b0;
    digit_reg = 32'd4321;
    tick();
    mode = 1'b0;
    digit_reg = 32'h0000_5678;
    wait_valid(lat, bc);
    check("msw_latency", 32'(lat), 32'(DATA_W + 1));
    check("msw_commit_digits", 32'(digits), 32'h4321);
    tick();
    check("msw_pt_digits", 32'(digits), 32'h5678);
    check("msw_pt_valid", 32'(valid), 32'd1);

    // Reset in the middle of a conversion
    mode = 1'b1;
    hold = 1'b0;
    digit_reg = 32'd4321;
    tick();
    hold = 1'b1;
    vc = 0;
    repeat (8) begin
      tick();
      if (valid) vc++;
    end
    check("mid_no_valid", 32'(vc), 32'd0);
    check("mid_state_shift", 32'(dbg_state), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_digits", 32'(digits), 32'h0000);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    tick();
    reset = 1'b1;
    vc = 0;
    repeat (20) begin
      tick();
      if (valid) vc++;
    end
    check("mid_no_commit", 32'(vc), 32'd0);
    check("mid_digits_still_zero", 32'(digits), 32'h0000);
    run_conv("after_rst", 32'd4321, 16'h4321, 1'b0, 4'b0000);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/digits_conv.md
Name: digits_conv

Overview:
- Parametrised successor to the fixed 4-digit display latch.
- Produces NDIG 4-bit digit codes for the seven-segment scanner from a 32-bit source register.
- Two modes:
  - BCD pass-through, with 1-cycle latency.
  - Binary-to-BCD conversion, using a sequential shift-add-3 (double-dabble) engine.
- Adds hold, conversion status, saturation on overflow, and optional leading-zero blanking. Sits between the CPU-visible display register and the segment multiplexer.

Parameters:
- NDIG, 4, number of output digits (1..8).
- DATA_W, 16, binary-mode input width; converts digit_reg[DATA_W-1:0] (1..32).
- BLANK_CODE, 4'hF, code driven on blanked digit positions (only with LZ_BLANK_EN).

Ports:
- clk_10Hz  input  1  display-domain clock
- reset  input  1  asynchronous, active-low reset
- digit_reg  input  32  source value (packed BCD or binary)
- mode  input  1  0 = BCD pass-through, 1 = binary conversion
- hold  input  1  1 = freeze outputs / suppress new capture
- digits  output  4*NDIG  digit codes; digit i = digits[4i+3:4i], i=0 is ones
- blank_mask  output  NDIG  1 = digit position blanked
- overflow  output  1  binary value exceeded 10^NDIG-1
- busy  output  1  conversion in progress
- valid  output  1  1-cycle pulse on every output update

Behaviour:
- Reset is asynchronous and active-low on clk_10Hz. While reset=0:
  - digits, blank_mask, overflow, busy, valid all 0.
  - FSM in IDLE; internal shift/BCD registers cleared.
- Reset mid-conversion aborts the conversion; no commit occurs.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - mode=0, hold=0: each edge, digits <= digit_reg[4*NDIG-1:0] (nibbles A-F passed unchanged); overflow <= 0; valid=1 for that cycle. Stay in IDLE.
  - mode=0, hold=1: outputs frozen; valid=0.
  - mode=1, hold=0: capture digit_reg[DATA_W-1:0] into the binary shift register; clear the BCD accumulator (4*NDIG bits) and the sticky overflow; bit counter=0; go to SHIFT; busy=1.
  - mode=1, hold=1: stay in IDLE; outputs unchanged.
- SHIFT, one bit per edge, DATA_W edges:
  - Every accumulator nibble >=5 gets +3.
  - Then {acc, bin} shifts left by 1.
  - The bit leaving the top nibble ORs into the sticky overflow.
  - After the DATA_W-th shift, go to COMMIT.
  - mode and hold are ignored while in SHIFT.
- COMMIT, one edge:
  - If sticky=1: digits <= all 4'h9, overflow <= 1.
  - Else: digits <= acc, overflow <= 0.
  - valid=1 for one cycle; busy <= 0; go to IDLE.
- Latency (binary mode):
  - Capture edge C; new digits/valid appear after edge C+DATA_W+1.
  - busy is high from after edge C until after edge C+DATA_W+1.
  - Minimum refresh period is DATA_W+2 cycles (1.8 s at defaults).
- digit_reg changes after capture do not affect the conversion in progress.
- Mode switch 1->0 during SHIFT: the conversion completes and commits, then BCD pass-through resumes on the following edge.
- blank_mask and the blanked codes are registered and update on the same edge as digits.

Optional Feature:
- Macro: LZ_BLANK_EN.
- Defined:
  - On each update, blank_mask[i]=1 iff digit i and all higher digits are 0, for i>=1.
  - blank_mask[0] is never set.
  - Blanked positions are driven as BLANK_CODE in digits.
  - Overflow saturation 9s are never blanked.
- Undefined: blank_mask is constant 0; digits carry raw values.

Test Plan:
- reset=0 with digit_reg=32'hFFFF_FFFF, mode=1 -> digits=16'h0000, busy=0, valid=0, overflow=0; release -> capture on first edge.
- mode=0, digit_reg=32'h0000_1234 -> digits=16'h1234 after 1 edge, valid high every edge; hold=1 then digit_reg=32'h5678 -> digits stays 16'h1234.
- mode=1, digit_reg=32'd4321 -> busy=1 for 17 cycles, digits=16'h4321, overflow=0, exactly one valid pulse per conversion.
- mode=1, digit_reg=32'd12345 -> digits=16'h9999, overflow=1; then 32'd9999 -> digits=16'h9999, overflow=0.
- LZ_BLANK_EN, mode=1, digit_reg=32'd7 -> digits=16'hFFF7, blank_mask=4'b1110; digit_reg=0 -> digits=16'hFFF0, blank_mask=4'b1110; undefined -> digits=16'h0007, blank_mask=0.
- mode=1, assert reset at SHIFT cycle 8 of 32'd4321 -> all outputs 0 immediately, no valid pulse; after release, a fresh conversion yields 16'h4321.
